tiaozhi_am: RTL
===============

TIAOZHI_AM -- requirements
Module: tiaozhi_am

Interface
REQ-001 Parameter: UPSAMPLE, default 16, clocks per baseband sample (legal range 2..1024).
REQ-002 clk_in  input  1  single system clock; all state rising-edge triggered.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  modulator enable.
REQ-005 fcw  input  24  carrier frequency control word, unsigned, sampled every clock.
REQ-006 mod_idx  input  8  modulation index, unsigned, 0..255 maps to 0..~1.
REQ-007 s_data  input  16  baseband sample, signed two's complement.
REQ-008 s_valid  input  1  s_data valid.
REQ-009 s_ready  output  1  sample-accept strobe.
REQ-010 underrun_clr  input  1  clears the underrun flag.
REQ-011 mod_out  output  16  AM output, signed.
REQ-012 carrier_out  output  8  carrier aligned to mod_out, signed, for coherent demodulation.
REQ-013 out_valid  output  1  mod_out/carrier_out valid.
REQ-014 underrun  output  1  sticky flag: strobe occurred with s_valid low.

Function
REQ-015 Phase accumulator acc (24 bit): acc <= acc + fcw mod 2^24 each clock with en=1; holds when en=0.
REQ-016 Carrier index k = acc[23:16]; carrier = round(127*sin(2*pi*k/256)), range -127..127, implemented as a constant table.
REQ-017 Sample counter cnt counts 0..UPSAMPLE-1 while en=1, wraps to 0, holds when en=0.
REQ-018 s_ready = en AND (cnt == UPSAMPLE-1), combinational, one clock wide.
REQ-019 Transfer when s_valid AND s_ready; hold register x_hold <= s_data on that edge; x_hold holds otherwise (zero-order hold).
REQ-020 s_ready=1 with s_valid=0: underrun <= 1, x_hold unchanged.
REQ-021 underrun_clr=1 clears underrun next edge; set condition in the same cycle wins (underrun stays 1).
REQ-022 Stage 1 (registered): c1 = carrier(k from current acc), p1 = x_hold * mod_idx (signed 16 x unsigned 8 -> 25-bit signed).
REQ-023 Stage 2 (registered): env = 16384 + (p1 >>> 9) (arithmetic shift, floor); env range 64..32703, never negative, no saturation; c2 = c1.
REQ-024 Stage 3 (registered): mod_out = (env * c2) >>> 7 (floor), range -32448..32447, fits 16 bits, no saturation; carrier_out = c2.
REQ-025 Latency: acc value at edge n appears at mod_out at edge n+3; pipeline stages advance every clock regardless of en.
REQ-026 out_valid = en delayed 3 clocks through a valid shift register.
REQ-027 When out_valid=0, mod_out and carrier_out are forced to 0.
REQ-028 fcw/mod_idx changes take effect on the next edge with no glitch handling; phase continuous across fcw change.

Reset
REQ-029 rst=0 asynchronously sets acc, cnt, x_hold, all pipeline registers, valid shift register, underrun to 0; mod_out=0, carrier_out=0, out_valid=0, s_ready=0.
REQ-030 After rst release the first accumulator update occurs on the first edge with en=1; reset mid-operation discards all in-flight pipeline data.

Verification
REQ-031 Reset: assert rst=0 mid-stream -> all outputs 0 immediately (before next edge); after release with en=1, out_valid rises on 3rd edge.
REQ-032 Carrier only: fcw=0x010000, mod_idx=0 -> carrier_out steps 0,3,6,9,...; at k=64 carrier_out=127, mod_out=16256; at k=192 mod_out=-16256.
REQ-033 Full modulation: mod_idx=255, x_hold=32767, carrier=127 -> env=32703, mod_out=32447; x_hold=-32768, carrier=-127 -> env=64, mod_out=-64.
REQ-034 Handshake, UPSAMPLE=16: s_ready pulses every 16 clocks; drop s_valid for one strobe -> underrun=1, x_hold unchanged; pulse underrun_clr alone -> underrun=0; clr coinciding with new underrun -> stays 1.
REQ-035 Wrap: fcw=0x400000 -> carrier_out repeats 0,127,0,-127 with period 4 clocks across acc wrap, no discontinuity.
REQ-036 en toggle: en low 5 clocks -> acc and cnt frozen, s_ready=0, out_valid falls 3 clocks after en falls; on en high carrier resumes at the frozen phase.

Source files
------------

// File: rtl/tiaozhi_am.sv
// AM modulator: a DDS carrier scaled by a (1 + m*x) envelope. The baseband input is
// zero-order held, and the product passes through a three-stage output pipeline.
module tiaozhi_am #(
  parameter int UPSAMPLE = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic [23:0]        fcw,
  input  logic [7:0]         mod_idx,
  input  logic signed [15:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               underrun_clr,
  output logic signed [15:0] mod_out,
  output logic signed [7:0]  carrier_out,
  output logic               out_valid,
  output logic               underrun
);

  localparam int CW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(UPSAMPLE - 1);

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64; other quadrants mirror/negate it
  localparam logic [6:0] QSIN [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  logic [23:0]        acc;
  logic [CW-1:0]      cnt;
  logic signed [15:0] x_hold;
  logic [6:0]         q_idx;
  logic [6:0]         q_mag;
  logic signed [7:0]  carrier;
  logic signed [7:0]  c1;
  logic signed [24:0] p1;
  logic [15:0]        env;
  logic signed [7:0]  c2;
  logic signed [24:0] prod;
  logic signed [15:0] mod_r;
  logic signed [7:0]  c3;
  logic [2:0]         vld;

  assign s_ready = en && (cnt == CNT_LAST);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc + fcw;
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // A set on the current strobe takes priority over a simultaneous clear
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      x_hold   <= '0;
      underrun <= 1'b0;
    end else begin
      if (s_ready && s_valid)
        x_hold <= s_data;
      if (s_ready && !s_valid)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

  always_comb begin
    q_idx   = acc[22] ? (7'd64 - {1'b0, acc[21:16]}) : {1'b0, acc[21:16]};
    q_mag   = QSIN[q_idx];
    carrier = acc[23] ? -$signed({1'b0, q_mag}) : $signed({1'b0, q_mag});
  end

  always_comb begin
    prod = 25'($signed({1'b0, env})) * 25'(c2);
  end

  // The pipeline runs every clock; en only travels alongside as the valid bit
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      c1    <= '0;
      p1    <= '0;
      env   <= '0;
      c2    <= '0;
      mod_r <= '0;
      c3    <= '0;
      vld   <= '0;
    end else begin
      c1    <= carrier;
      p1    <= 25'(x_hold) * 25'($signed({1'b0, mod_idx}));
      env   <= 16'(25'sd16384 + (p1 >>> 9));
      c2    <= c1;
      mod_r <= 16'(prod >>> 7);
      c3    <= c2;
      vld   <= {vld[1:0], en};
    end
  end

  assign out_valid   = vld[2];
  assign mod_out     = vld[2] ? mod_r : '0;
  assign carrier_out = vld[2] ? c3 : '0;

endmodule
